// File: rtl/elpis_mem_pkg.sv
// Shared constants and types for the line-memory arbiter.
// pick_winner resolves a request pair; the caller supplies the client preferred on a tie.
package elpis_mem_pkg;

    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    typedef enum logic {
        CLIENT_IC = 1'b0,
        CLIENT_DC = 1'b1
    } client_t;

    function automatic client_t pick_winner(input logic ic_req, input logic dc_req,
                                            input client_t tie_pref);
        client_t w_win;
        if (ic_req && !dc_req) begin
            w_win = CLIENT_IC;
        end else if (dc_req && !ic_req) begin
            w_win = CLIENT_DC;
        end else begin
            w_win = tie_pref;
        end
        return w_win;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Client and memory signals of the line arbiter. Clients hold req until their one-cycle
// done; the memory accepts a transaction in a cycle where requested and ready are both high.
interface mem_line_arbiter_if #(
    parameter int ADDR_W = elpis_mem_pkg::ADDR_W,
    parameter int LINE_W = elpis_mem_pkg::LINE_W
);
    logic              is_loading_memory_into_core;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_rd_data;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wr_data;
    logic              dc_done;
    logic [LINE_W-1:0] dc_rd_data;
    logic              mem_requested;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_reset_mem_req;
    logic [LINE_W-1:0] mem_rd_data;
    logic              mem_ready;

    modport master (
        input  is_loading_memory_into_core,
        input  ic_req, ic_addr,
        output ic_done, ic_rd_data,
        input  dc_req, dc_we, dc_addr, dc_wr_data,
        output dc_done, dc_rd_data,
        output mem_requested, mem_we, mem_addr, mem_wr_data, mem_reset_mem_req,
        input  mem_rd_data, mem_ready
    );

    modport slave (
        output is_loading_memory_into_core,
        output ic_req, ic_addr,
        input  ic_done, ic_rd_data,
        output dc_req, dc_we, dc_addr, dc_wr_data,
        input  dc_done, dc_rd_data,
        input  mem_requested, mem_we, mem_addr, mem_wr_data, mem_reset_mem_req,
        output mem_rd_data, mem_ready
    );

endinterface

// File: rtl/mem_arb_select.sv
// Grant selection and the latched id of the granted client.
// MEM_ARB_ROUND_ROBIN_EN: ties alternate using the latched id; otherwise dcache wins ties.
module mem_arb_select (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ic_req,
    input  logic                  i_dc_req,
    input  logic                  i_take,
    output logic                  o_any_req,
    output elpis_mem_pkg::client_t o_winner,
    output elpis_mem_pkg::client_t o_grant
);
    import elpis_mem_pkg::*;

    client_t r_grant;
    client_t w_tie_pref;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // The latched id is the last grant; reset to icache so the first tie goes to dcache.
    assign w_tie_pref = (r_grant == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
`else
    assign w_tie_pref = CLIENT_DC;
`endif

    assign o_any_req = i_ic_req | i_dc_req;
    assign o_winner  = pick_winner(i_ic_req, i_dc_req, w_tie_pref);
    assign o_grant   = r_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= CLIENT_IC;
        end else if (i_take) begin
            r_grant <= o_winner;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Serialises icache/dcache line transactions onto the shared 128-bit line memory.
// Tie policy is selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select).
module mem_line_arbiter #(
    parameter int ADDR_W = elpis_mem_pkg::ADDR_W,
    parameter int LINE_W = elpis_mem_pkg::LINE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_line_arbiter_if.master        bus,
    output elpis_mem_pkg::arb_state_t o_dbg_state
);
    import elpis_mem_pkg::*;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [LINE_W-1:0] r_wr_data;
    logic [LINE_W-1:0] r_ic_rd_data;
    logic [LINE_W-1:0] r_dc_rd_data;
    logic              r_ic_done;
    logic              r_dc_done;

    logic    w_take;
    logic    w_abort;
    logic    w_mem_req;
    logic    w_mem_we;
    logic    w_any_req;
    logic    w_settle_done;
    logic    w_loading;
    client_t w_winner;
    client_t w_grant;

    assign w_loading = bus.is_loading_memory_into_core;

    mem_arb_select u_select (
        .clk       (clk),
        .reset     (reset),
        .i_ic_req  (bus.ic_req),
        .i_dc_req  (bus.dc_req),
        .i_take    (w_take),
        .o_any_req (w_any_req),
        .o_winner  (w_winner),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_abort      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_loading && w_any_req) begin
                    w_take       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (w_loading) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_mem_req = 1'b1;
                    w_mem_we  = r_we;
                    if (bus.mem_ready) begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // Held through the countdown, dropped the cycle ready returns so nothing relaunches.
                if (w_loading) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_mem_req = !bus.mem_ready;
                    w_mem_we  = r_we & !bus.mem_ready;
                    if (bus.mem_ready) begin
                        w_next_state = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (w_loading) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wr_data <= '0;
        end else if (w_take) begin
            if (w_winner == CLIENT_DC) begin
                r_addr    <= bus.dc_addr;
                r_we      <= bus.dc_we;
                r_wr_data <= bus.dc_wr_data;
            end else begin
                r_addr    <= bus.ic_addr;
                r_we      <= 1'b0;
                r_wr_data <= '0;
            end
        end
    end

    // The lagged last read word is on mem_rd_data by the end of SETTLE.
    assign w_settle_done = (r_state == SETTLE) && (w_next_state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ic_done    <= 1'b0;
            r_dc_done    <= 1'b0;
            r_ic_rd_data <= '0;
            r_dc_rd_data <= '0;
        end else begin
            r_ic_done <= w_settle_done && (w_grant == CLIENT_IC);
            r_dc_done <= w_settle_done && (w_grant == CLIENT_DC);
            if (w_settle_done && !r_we) begin
                if (w_grant == CLIENT_IC) begin
                    r_ic_rd_data <= bus.mem_rd_data;
                end else begin
                    r_dc_rd_data <= bus.mem_rd_data;
                end
            end
        end
    end

    assign bus.ic_done           = r_ic_done;
    assign bus.dc_done           = r_dc_done;
    assign bus.ic_rd_data        = r_ic_rd_data;
    assign bus.dc_rd_data        = r_dc_rd_data;
    assign bus.mem_requested     = w_mem_req;
    assign bus.mem_we            = w_mem_we;
    assign bus.mem_addr          = r_addr;
    assign bus.mem_wr_data       = r_wr_data;
    assign bus.mem_reset_mem_req = reset | w_abort;
    assign o_dbg_state           = r_state;

endmodule
